uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame.
REQ-002 SHALL have parameter CLK_FREQ_HZ, default 50_250_000, meaning the clk_i frequency (PLL output).
REQ-003 SHALL have parameter BAUD_RATE, default 9600, meaning line bit rate.
REQ-004 SHALL have port clk_i, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1, meaning reset; it is asynchronous and active-low.
REQ-006 SHALL have port data_i, input, DATA_WIDTH, meaning the byte to transmit.
REQ-007 SHALL have port valid_i, input, 1, meaning data_i is valid.
REQ-008 SHALL have port ready_o, output, 1, meaning the block can accept a byte.
REQ-009 SHALL have port tx_o, output, 1, meaning the serial line (idle high).
REQ-010 SHALL have port busy_o, output, 1, meaning a frame is in progress.

Function
REQ-011 SHALL compute CYCLES_PER_BIT = CLK_FREQ_HZ / BAUD_RATE with integer floor division (default 5234).
REQ-012 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; PARITY is reachable only when the parity feature is compiled in.
REQ-013 SHALL assert ready_o only in IDLE; a handshake occurs on a clock edge where valid_i and ready_o are both 1.
REQ-014 SHALL, on handshake, latch data_i into a shift register and move to START; tx_o falls on the next cycle (1-cycle latency).
REQ-015 SHALL hold each line bit for exactly CYCLES_PER_BIT cycles.
REQ-016 SHALL send START as 0, then the DATA_WIDTH data bits MSB first, optionally PARITY, then STOP as 1.
REQ-017 SHALL ignore changes on data_i and valid_i while busy_o=1; the latched byte is transmitted unchanged.
REQ-018 SHALL return to IDLE after the STOP bit period, then assert ready_o on the following cycle.
REQ-019 SHALL support back-to-back frames: if valid_i is held high, the next START begins 1 cycle after ready_o rises, with no extra idle bit.
REQ-020 SHALL drive busy_o = (state != IDLE).
REQ-021 SHALL keep tx_o registered (glitch-free), and SHALL keep tx_o = 1 in IDLE and STOP.
REQ-022 SHALL track data bits with a bit counter of width $clog2(DATA_WIDTH); it wraps to 0 on leaving DATA.

Reset
REQ-023 SHALL, while rst_ni=0, force state=IDLE, tx_o=1, busy_o=0, ready_o=0, and clear the baud counter, bit counter and shift register.
REQ-024 SHALL assert ready_o on the first clock edge after rst_ni deasserts.
REQ-025 SHALL, on reset mid-frame, abort the frame immediately with tx_o=1; no partial frame resumes.

Configuration
REQ-026 SHALL, when UART_TX_PARITY_EN is defined, insert an even-parity bit (XOR of all data bits) after the data bits, giving a frame of DATA_WIDTH+3 bits.
REQ-027 SHALL, when UART_TX_PARITY_EN is undefined, emit no PARITY state or logic, giving a frame of DATA_WIDTH+2 bits.

Structure
REQ-028 SHALL place the state enum type and the CYCLES_PER_BIT calculation in the shared package uart_pkg.
REQ-029 SHALL implement bit timing in the sub-module uart_baud_counter; it outputs a 1-cycle tick after every CYCLES_PER_BIT cycles and reloads to 0 when a frame starts.

Verification
REQ-030 SHALL cover: reset, then valid_i=1 with data_i=8'hA5 -> tx_o line 0,1,0,1,0,0,1,0,1,1 with each bit 5234 cycles, busy_o high for 52340 cycles.
REQ-031 SHALL cover: with UART_TX_PARITY_EN, data_i=8'h07 -> parity bit 1 before STOP; frame is 57574 cycles.
REQ-032 SHALL cover: back-to-back 8'h00 then 8'hFF with valid_i held high -> second START falls 1 cycle after ready_o rises; 8'hFF is decoded correctly.
REQ-033 SHALL cover: data_i changed from 8'h3C to 8'hC3 mid-frame -> line still carries 8'h3C.
REQ-034 SHALL cover: rst_ni pulsed low during bit 4 of 8'h55 -> tx_o=1 within 0 cycles (async), ready_o=1 one cycle after release.
REQ-035 SHALL cover: loopback of tx_o into the existing UART receiver at 9600 baud, sending 8'h00..8'hFF -> all 256 bytes received in order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared state type and bit-timing helper for the UART transmitter.
// Optional even parity is compiled in with UART_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } uart_state_e;

  // Integer floor division; any fractional cycle per bit is dropped.
  function automatic int calc_cycles_per_bit(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

  localparam int CYCLES_PER_BIT_DEFAULT = calc_cycles_per_bit(50_250_000, 9600);

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: emits a one-cycle tick at the end of every CYCLES_PER_BIT
// cycles while enabled; clr_i restarts the period at the beginning of a frame.
module uart_baud_counter #(
  parameter int CYCLES_PER_BIT = 5234
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CNT_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i || !en_i) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH bits MSB first, optional even parity
// (UART_TX_PARITY_EN), stop bit. Handshake: a byte is taken on a rising edge
// where valid_i and ready_o are both 1; ready_o is high only while idle.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int CLK_FREQ_HZ = 50_250_000,
  parameter int BAUD_RATE   = 9600
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  tx_o,
  output logic                  busy_o,
  output uart_state_e           state_o
);

  localparam int CYCLES_PER_BIT = calc_cycles_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int BIT_CNT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  tx_q, tx_d;
  logic                  ready_q;
  logic                  handshake;
  logic                  tick;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q;
`endif

  assign handshake = valid_i && ready_q;

  uart_baud_counter #(
    .CYCLES_PER_BIT(CYCLES_PER_BIT)
  ) u_baud (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (state_q != IDLE),
    .clr_i  (handshake),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d = START;
          shift_d = data_i;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            shift_d   = shift_q << 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The line level is derived from the next state so tx_o changes on the same
  // edge as the state register and leaves the flop glitch-free.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[DATA_WIDTH-1];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = parity_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      ready_q   <= (state_d == IDLE);
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      parity_q <= 1'b0;
    end else if (handshake) begin
      parity_q <= ^data_i;
    end
  end
`endif

  assign ready_o = ready_q;
  assign tx_o    = tx_q;
  assign busy_o  = (state_q != IDLE);
  assign state_o = state_q;

endmodule
